serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Digit-serial two's-complement subtractor: computes diff = a - b, DIGIT bits per clock.
//  Subtraction is the inverse of the ripple-carry add path: a + ~b, with the carry-in of
//  digit 0 forced to 1.
//  Operands enter through a valid/ready handshake; the result is held under a second
//  valid/ready handshake.
//  Sits between the board switch/LED glue and any multi-cycle arithmetic datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT, >= DIGIT
//  DIGIT  2  bits processed per RUN cycle; NDIG = WIDTH/DIGIT cycles per operation
// PORTS
//  clk           in   1      single clock, all state updates on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start_valid   in   1      operands a/b valid
//  start_ready   out  1      block can accept operands (high only in IDLE)
//  a             in   WIDTH  minuend; sampled only on the accept edge
//  b             in   WIDTH  subtrahend; sampled only on the accept edge
//  result_valid  out  1      diff/borrow/overflow/zero valid (high only in DONE)
//  result_ready  in   1      consumer accepts the result
//  diff          out  WIDTH  a - b mod 2^WIDTH
//  borrow        out  1      unsigned borrow: 1 iff a < b (= ~final carry)
//  overflow      out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//  zero          out  1      diff == 0
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, start_ready=1, result_valid=0, busy=0;
//    diff/borrow/overflow/zero=0; operand, carry and digit-count regs cleared.
//  FSM: IDLE -> RUN on start_valid&&start_ready; RUN -> DONE when the last digit
//    completes; DONE -> IDLE on result_valid&&result_ready. No other transitions.
//  Accept edge: capture a into a_sh, ~b into b_sh, carry=1, idx=0; raw a[MSB], b[MSB]
//    kept for overflow.
//  RUN, each cycle: DIGIT-bit add of a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry.
//    Sum shifts into diff from the MSB end; a_sh/b_sh shift right by DIGIT.
//    Carry register updates; idx increments.
//  RUN completes NDIG digits: result_valid rises exactly NDIG clocks after the accept edge
//    (WIDTH=8, DIGIT=2 -> 4).
//  Flags: borrow, overflow and zero are registered on the same edge that enters DONE.
//    diff/flags are stable throughout DONE.
//  Backpressure: DONE holds indefinitely while result_ready=0; outputs do not change.
//  start_valid in RUN/DONE: ignored (start_ready=0); the operands are not queued.
//  result_ready outside DONE: ignored.
//  Result handshake edge: returns to IDLE; start_ready=1 the next cycle.
//    No same-cycle re-accept, so minimum issue interval = NDIG+2 cycles.
//  Outputs after return to IDLE: diff/flags hold their last values; result_valid=0
//    qualifies them.
//  Reset mid-RUN or mid-DONE: operation abandoned, all reset values restored immediately.
//    No partial result ever appears.
//  a==b: diff=0, zero=1, borrow=0, overflow=0.
//  a=0,b=0: same as a==b.
// STRUCTURE
//  Package serial_sub_pkg:
//    - state enum {S_IDLE, S_RUN, S_DONE} (2-bit);
//    - localparam helper NDIG(WIDTH,DIGIT);
//    - idx width = $clog2(NDIG)+1.
//  Sub-module digit_adder #(DIGIT): combinational cin, a, b -> s, cout, built as a chain of
//    1-bit full-adder cells. Instantiated once in the RUN datapath.
//  Elaboration check: error if WIDTH % DIGIT != 0.
// TESTING (WIDTH=8, DIGIT=2 unless noted)
//  1 a=200,b=55, result_ready=1
//    -> diff=145, borrow=0, overflow=0, zero=0; result_valid exactly 4 clks after accept.
//  2 a=5,b=10 -> diff=251 (0xFB), borrow=1, overflow=0.
//    a=0x80,b=0x01 -> diff=0x7F, borrow=0, overflow=1.
//  3 a=b=0xA5 -> diff=0, zero=1, borrow=0.
//    Hold result_ready=0 for 10 clks -> result_valid and diff stable; then handshake
//    -> IDLE, start_ready=1 next clk.
//  4 Pulse start_valid with a=1,b=1 during RUN of op a=9,b=3 -> ignored; result diff=6;
//    exactly one result produced.
//  5 Deassert rst_n mid-RUN (idx=2), asynchronously between edges
//    -> start_ready=1, result_valid=0, diff=0 without waiting for a clock edge;
//    next op a=7,b=7 -> zero=1.
//  6 WIDTH=16, DIGIT=4: random 1000 ops vs a-b reference model, random backpressure
//    -> all match; latency 4.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_t : FSM encoding (IDLE / RUN / DONE)
//   ndig    : number of digit cycles per operation (WIDTH / DIGIT)
//   idx_w   : width of the digit counter, one spare bit above $clog2(NDIG)
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int idx_w(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder built from 1-bit full-adder cells.
//   cin      : carry into bit 0
//   a, b     : DIGIT-bit addends
//   s        : DIGIT-bit sum
//   cout     : carry out of the top bit
module digit_adder
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic             cin,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial two's-complement subtractor, diff = a - b,
// DIGIT bits per clock, computed as a + ~b with carry-in 1 on the first digit.
//   clk, rst_n                : clock, async active-low reset
//   start_valid / start_ready : operand handshake (ready only in IDLE)
//   a, b                      : minuend / subtrahend, sampled on the accept edge
//   result_valid/result_ready : result handshake (valid only in DONE)
//   diff                      : a - b mod 2^WIDTH
//   borrow                    : 1 iff a < b unsigned
//   overflow                  : signed overflow of the subtraction
//   zero                      : diff == 0
//   busy                      : operation in flight (state != IDLE)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int IW   = idx_w(WIDTH, DIGIT);

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_param_chk
        $error("serial_subtractor: WIDTH must be a nonzero multiple of DIGIT");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             a_msb, b_msb;

    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic [WIDTH-1:0] diff_next;
    logic             accept;
    logic             last_digit;

    assign start_ready  = (state == S_IDLE);
    assign result_valid = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign accept       = start_valid && start_ready;
    assign last_digit   = (idx == IW'(NDIG - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .cin  (carry),
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .s    (dsum),
        .cout (dcout)
    );

    // Result fills from the MSB end so that after NDIG digits the first
    // (least significant) digit has reached bit 0.
    if (DIGIT == WIDTH) begin : g_diff_one
        assign diff_next = dsum;
    end else begin : g_diff_shift
        assign diff_next = {dsum, diff[WIDTH-1:DIGIT]};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next-state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept)       state_next = S_RUN;
            S_RUN:   if (last_digit)   state_next = S_DONE;
            S_DONE:  if (result_ready) state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= ~b;
                        carry <= 1'b1;
                        idx   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= dcout;
                    idx   <= idx + 1'b1;
                    diff  <= diff_next;
                    // Flags come from the completed value on the edge into DONE.
                    if (last_digit) begin
                        borrow   <= ~dcout;
                        overflow <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
                        zero     <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8, DIGIT=2 instance
    logic       sv8 = 0, sr8, rv8, rr8 = 0, bo8, ov8, z8, busy8;
    logic [7:0] a8 = 0, b8 = 0, d8;
    // WIDTH=16, DIGIT=4 instance
    logic        sv16 = 0, sr16, rv16, rr16 = 0, bo16, ov16, z16, busy16;
    logic [15:0] a16 = 0, b16 = 0, d16;

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
        .result_valid(rv8), .result_ready(rr8), .diff(d8), .borrow(bo8),
        .overflow(ov8), .zero(z8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(sr16), .a(a16), .b(b16),
        .result_valid(rv16), .result_ready(rr16), .diff(d16), .borrow(bo16),
        .overflow(ov16), .zero(z16), .busy(busy16)
    );

    // Issue one 8-bit op from IDLE; returns clocks from accept edge to result_valid.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(posedge clk); #1;
        sv8 = 1; a8 = a; b8 = b;
        @(posedge clk); #1;
        sv8 = 0;
        lat = 0;
        while (!rv8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack8();
        rr8 = 1;
        @(posedge clk); #1;
        rr8 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        n_cmp++;
        if ({sr8, rv8, busy8, d8, bo8, ov8, z8} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'b000}) begin
            n_err++;
            $display("FAIL reset8: got sr=%b rv=%b busy=%b d=%h flags=%b%b%b want 1 0 0 00 000",
                     sr8, rv8, busy8, d8, bo8, ov8, z8);
        end
        n_cmp++;
        if ({sr16, rv16, busy16, d16} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset16: got sr=%b rv=%b busy=%b d=%h want 1 0 0 0000", sr16, rv16, busy16, d16);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_basic();
        int lat;
        drive8(8'd200, 8'd55, lat);
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_cmp++;
        if ({d8, bo8, ov8, z8} !== {8'd145, 3'b000}) begin
            n_err++;
            $display("FAIL basic_200_55: got d=%0d b=%b o=%b z=%b want 145 0 0 0", d8, bo8, ov8, z8);
        end
        ack8();
    endtask

    task automatic test_flags();
        int lat;
        drive8(8'd5, 8'd10, lat);
        n_cmp++;
        if ({d8, bo8, ov8, z8} !== {8'hFB, 3'b100}) begin
            n_err++;
            $display("FAIL borrow_5_10: got d=%h b=%b o=%b z=%b want fb 1 0 0", d8, bo8, ov8, z8);
        end
        ack8();
        drive8(8'h80, 8'h01, lat);
        n_cmp++;
        if ({d8, bo8, ov8, z8} !== {8'h7F, 3'b010}) begin
            n_err++;
            $display("FAIL ovf_80_01: got d=%h b=%b o=%b z=%b want 7f 0 1 0", d8, bo8, ov8, z8);
        end
        ack8();
        drive8(8'h00, 8'h00, lat);
        n_cmp++;
        if ({d8, bo8, ov8, z8} !== {8'h00, 3'b001}) begin
            n_err++;
            $display("FAIL zero_0_0: got d=%h b=%b o=%b z=%b want 00 0 0 1", d8, bo8, ov8, z8);
        end
        ack8();
    endtask

    task automatic test_backpressure();
        int lat;
        drive8(8'hA5, 8'hA5, lat);
        n_cmp++;
        if ({d8, bo8, ov8, z8} !== {8'h00, 3'b001}) begin
            n_err++;
            $display("FAIL equal_a5: got d=%h b=%b o=%b z=%b want 00 0 0 1", d8, bo8, ov8, z8);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rv8, sr8, d8, z8} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
                n_err++;
                $display("FAIL hold_%0d: got rv=%b sr=%b d=%h z=%b want 1 0 00 1", i, rv8, sr8, d8, z8);
            end
        end
        ack8();
        n_cmp++;
        if ({rv8, sr8, busy8} !== 3'b010) begin
            n_err++;
            $display("FAIL after_ack: got rv=%b sr=%b busy=%b want 0 1 0", rv8, sr8, busy8);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(posedge clk); #1;
        sv8 = 1; a8 = 8'd9; b8 = 8'd3;
        @(posedge clk); #1;
        sv8 = 0;
        @(posedge clk); #1;
        sv8 = 1; a8 = 8'd1; b8 = 8'd1;    // must be ignored while running
        @(posedge clk); #1;
        sv8 = 0;
        lat = 2;
        while (!rv8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL ignore_latency: got %0d want 4", lat); end
        n_cmp++;
        if ({d8, z8} !== {8'd6, 1'b0}) begin
            n_err++;
            $display("FAIL ignore_9_3: got d=%0d z=%b want 6 0", d8, z8);
        end
        ack8();
        repeat (8) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rv8, busy8} !== 2'b00) begin
                n_err++;
                $display("FAIL single_result: got rv=%b busy=%b want 0 0", rv8, busy8);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(posedge clk); #1;
        sv8 = 1; a8 = 8'hFF; b8 = 8'h00;
        @(posedge clk); #1;           // accept edge passed, idx=0
        sv8 = 0;
        @(posedge clk); #1;           // idx=1
        @(posedge clk); #1;           // idx=2
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({sr8, rv8, busy8, d8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL async_reset: got sr=%b rv=%b busy=%b d=%h want 1 0 0 00", sr8, rv8, busy8, d8);
        end
        @(posedge clk); #1;
        rst_n = 1;
        drive8(8'd7, 8'd7, lat);
        n_cmp++;
        if ({lat, d8, bo8, ov8, z8} !== {32'd4, 8'h00, 3'b001}) begin
            n_err++;
            $display("FAIL post_reset_7_7: got lat=%0d d=%h b=%b o=%b z=%b want 4 00 0 0 1",
                     lat, d8, bo8, ov8, z8);
        end
        ack8();
    endtask

    task automatic test_random16();
        int lat, k;
        int ea, eb, ed;
        logic ebo, eov, ez, hs;
        for (int n = 0; n < 1000; n++) begin
            ea = int'($urandom_range(0, 65535));
            eb = int'($urandom_range(0, 65535));
            if (n == 0) begin ea = 16'hFFFF; eb = 16'hFFFF; end
            if (n == 1) begin ea = 0;        eb = 1;        end
            if (n == 2) begin ea = 16'h8000; eb = 1;        end
            if (n == 3) begin ea = 16'h7FFF; eb = 16'hFFFF; end
            ed  = (ea - eb) & 16'hFFFF;
            ebo = (ea < eb);
            eov = (ea[15] != eb[15]) && (ed[15] != ea[15]);
            ez  = (ed == 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            sv16 = 1; a16 = ea[15:0]; b16 = eb[15:0];
            @(posedge clk); #1;
            sv16 = 0;
            lat = 0;
            while (!rv16 && lat < 20) begin
                sv16 = 1'($urandom_range(0, 1));
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            sv16 = 0;
            n_cmp++;
            if (lat !== 4) begin n_err++; $display("FAIL rnd_latency op%0d: got %0d want 4", n, lat); end
            n_cmp++;
            if ({d16, bo16, ov16, z16} !== {ed[15:0], ebo, eov, ez}) begin
                n_err++;
                $display("FAIL rnd_result op%0d a=%h b=%h: got d=%h b=%b o=%b z=%b want %h %b %b %b",
                         n, ea[15:0], eb[15:0], d16, bo16, ov16, z16, ed[15:0], ebo, eov, ez);
            end
            k = 0;
            hs = 0;
            while (!hs && k < 50) begin
                rr16 = 1'($urandom_range(0, 1));
                hs = rr16;
                @(posedge clk); #1;
                rr16 = 0;
                k++;
                if (!hs) begin
                    n_cmp++;
                    if ({rv16, d16, bo16, ov16, z16} !== {1'b1, ed[15:0], ebo, eov, ez}) begin
                        n_err++;
                        $display("FAIL rnd_hold op%0d: got rv=%b d=%h want 1 %h", n, rv16, d16, ed[15:0]);
                    end
                end
            end
            n_cmp++;
            if ({hs, rv16, sr16} !== 3'b101) begin
                n_err++;
                $display("FAIL rnd_ack op%0d: got hs=%b rv=%b sr=%b want 1 0 1", n, hs, rv16, sr16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_ignore_start();
        test_reset_mid_run();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
